multicycle_ctrl_v2: RTL and testbench
=====================================

Name: multicycle_ctrl_v2

Overview:
- Next-generation control FSM for the multi-cycle MIPS datapath.
- Adds three things to the current controller:
  - memory-ready handshake with wait states on every memory access state;
  - a parametrised memory timeout that traps;
  - JR support and an illegal-opcode trap.
- Drives the same datapath muxes and enables, with widened selects for JAL link and JR.
- Sits between the instruction register (op/funct fields) and the datapath/memory interface.

Parameters:
- MEM_TIMEOUT, 15: max wait cycles in a memory state before trapping; 0 disables the timeout.
- TRAP_ILLEGAL, 1: 1 = an unknown opcode goes to TRAP; 0 = it is decoded as R-type.
- STATE_W, 5: width of the state output.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- OP  in  6  instruction opcode field.
- funct  in  6  instruction funct field.
- mem_ready  in  1  memory completes the current access this cycle.
- RegDst  out  2  write register select: 00 rt, 01 rd, 10 $31.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 PC, 1 A register.
- ALUSrcB  out  2  ALU B select: 00 B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct, 11 immediate logic.
- ALUctrInst  out  1  immediate-logic instruction (zero-extend hint).
- IorD  out  1  memory address select: 0 PC, 1 ALUOut.
- IRWrite  out  1  instruction register load.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- MemtoReg  out  2  write-back data select: 00 ALUOut, 01 MDR, 10 PC.
- PCWriteCond  out  1  conditional PC write.
- PCWrite  out  1  unconditional PC write.
- PCCondSrc  out  1  branch condition: 1 BEQ, 0 BNE.
- PCSource  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target, 11 A register.
- trap  out  1  controller halted.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- state  out  STATE_W  current state, for debug.

Behaviour:
- Reset (synchronous): state = IDLE (5'h1F), wait counter = 0, trap = 0, trap_cause = 00.
- Outputs are Moore decoded from state; the only exceptions are IRWrite and PCWrite in IF, which are qualified by mem_ready.
- Every control output not listed for a state is 0. All outputs are 0 in IDLE.
- IDLE -> IF unconditionally.
- IF (0):
  - MemRead=1, ALUSrcB=01.
  - IRWrite = PCWrite = mem_ready.
  - Holds while !mem_ready; goes to ID on mem_ready.
- ID (1):
  - ALUSrcB=11.
  - Decode OP: 000000 with funct 001000 -> JR; other 000000 -> EX_R; 000010 -> J; 000011 -> JAL_LINK; 001000 -> EX_I; 001100/001101 -> EX_LOGI; 100011/101011 -> EX_LS; 000100 -> BEQ; 000101 -> BNE.
  - Any other OP -> TRAP with cause 01 if TRAP_ILLEGAL=1, otherwise EX_R.
- EX_LS (2): ALUSrcA=1, ALUSrcB=10. Goes to MEM_RD for 100011, MEM_ST for 101011.
- MEM_RD (3): MemRead=1, IorD=1. Holds until mem_ready, then goes to WB_LS.
- WB_LS (4): RegWrite=1, RegDst=00, MemtoReg=01. Goes to IF.
- MEM_ST (5): MemWrite=1, IorD=1. Holds until mem_ready, then goes to IF.
- EX_R (6): ALUSrcA=1, ALUOp=10. Goes to WB_R.
- WB_R (7): RegWrite=1, RegDst=01. Goes to IF.
- BEQ (8) / BNE (10):
  - ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - PCCondSrc=1 in BEQ only.
  - Goes to IF.
- J (9): PCWrite=1, PCSource=10. Goes to IF.
- EX_I (11): ALUSrcA=1, ALUSrcB=10. Goes to WB_I.
- WB_I (12): RegWrite=1, RegDst=00, MemtoReg=00. Goes to IF.
- JAL_LINK (13): RegWrite=1, RegDst=10, MemtoReg=10. Goes to J.
- EX_LOGI (14): ALUSrcA=1, ALUSrcB=10, ALUOp=11, ALUctrInst=1. Goes to WB_I.
- JR (15): PCWrite=1, PCSource=11. Goes to IF.
- TRAP (16):
  - trap=1; all other controls 0.
  - trap_cause is latched on entry.
  - Absorbing; only rst leaves it.
- Wait counter:
  - Cleared on entry to IF/MEM_RD/MEM_ST and in every other state.
  - Increments each cycle the FSM is in one of those states with mem_ready=0.
  - With MEM_TIMEOUT>0: when counter == MEM_TIMEOUT and mem_ready=0, the next state is TRAP with cause 10.
  - mem_ready=1 in that same cycle wins; no trap.
- rst asserted mid-wait or mid-instruction aborts immediately. No memory request is asserted in the following cycle (IDLE).
- Unused encodings (17..30) go to IDLE.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encoding constants;
  - opcode/funct constants;
  - select-field encodings (RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource);
  - trap-cause codes.
- One sub-module, mem_wait_timer: counter plus timeout compare, parametrised by MEM_TIMEOUT. Inputs are clear, waiting and mem_ready; output is expired.

Test Plan:
- rst for 2 cycles, then OP=000000, funct=100000, mem_ready=1 -> states 1F,0,1,6,7,0; RegWrite=1 and RegDst=01 in state 7 only.
- LW (OP=100011), mem_ready low for 3 cycles in IF and 2 in MEM_RD:
  - IF lasts 4 cycles; IRWrite=1 only on its last cycle.
  - MEM_RD lasts 3 cycles; MemtoReg=01 in WB_LS.
- JAL (OP=000011) -> 1 cycle JAL_LINK with RegDst=10, MemtoReg=10, RegWrite=1; then J with PCWrite=1, PCSource=10.
- OP=111111 with TRAP_ILLEGAL=1 -> state 16 after ID, trap=1, cause=01, held 20 cycles; rst returns to IDLE.
- MEM_TIMEOUT=15, SW with mem_ready stuck at 0 -> 16 cycles in MEM_ST, then TRAP with cause 10.
- Repeat that run with mem_ready=1 on cycle 16 -> goes to IF, no trap.
- OP=000000, funct=001000 -> JR with PCWrite=1, PCSource=11.
- rst asserted mid-MEM_RD -> next cycle state=1F, MemRead=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control FSM:
//   - state encoding (also exported on the debug state port)
//   - opcode / funct field values the decoder recognises
//   - encodings of the datapath select fields
//   - trap cause codes
// No ports; imported by multicycle_ctrl_v2 and its helpers.
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

   typedef enum logic [4:0] {
      S_IF       = 5'd0,
      S_ID       = 5'd1,
      S_EX_LS    = 5'd2,
      S_MEM_RD   = 5'd3,
      S_WB_LS    = 5'd4,
      S_MEM_ST   = 5'd5,
      S_EX_R     = 5'd6,
      S_WB_R     = 5'd7,
      S_BEQ      = 5'd8,
      S_J        = 5'd9,
      S_BNE      = 5'd10,
      S_EX_I     = 5'd11,
      S_WB_I     = 5'd12,
      S_JAL_LINK = 5'd13,
      S_EX_LOGI  = 5'd14,
      S_JR       = 5'd15,
      S_TRAP     = 5'd16,
      S_IDLE     = 5'd31
   } ctrlState_t;

   // Opcode and funct values
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FUNCT_JR = 6'b001000;

   // Select-field encodings
   localparam logic [1:0] REGDST_RT    = 2'b00;
   localparam logic [1:0] REGDST_RD    = 2'b01;
   localparam logic [1:0] REGDST_RA    = 2'b10;
   localparam logic [1:0] MEMTOREG_ALU = 2'b00;
   localparam logic [1:0] MEMTOREG_MDR = 2'b01;
   localparam logic [1:0] MEMTOREG_PC  = 2'b10;
   localparam logic [1:0] ALUB_B       = 2'b00;
   localparam logic [1:0] ALUB_FOUR    = 2'b01;
   localparam logic [1:0] ALUB_IMM     = 2'b10;
   localparam logic [1:0] ALUB_IMMSH   = 2'b11;
   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_SUB    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
   localparam logic [1:0] ALUOP_LOGI   = 2'b11;
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REG    = 2'b11;

   // Trap causes
   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // States that wait on the memory handshake
   function automatic logic isMemState(ctrlState_t s);
      return (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_ST);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts stalled cycles in a memory-access state and flags a timeout.
//   clk, rst   clock and synchronous active-high reset
//   clear      zero the count (set outside memory states and on state change)
//   waiting    FSM is in a memory-access state
//   mem_ready  memory completes the access this cycle
//   expired    count has reached MEM_TIMEOUT and memory is still not ready
// MEM_TIMEOUT = 0 removes the counter and never expires.
// ---------------------------------------------------------------------------
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic waiting,
   input  logic mem_ready,
   output logic expired
);

   generate
      if (MEM_TIMEOUT > 0) begin : gTimeout
         localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
         logic [CNT_W-1:0] countReg;

         // The count never passes MEM_TIMEOUT: reaching it with memory still
         // stalled sends the FSM to TRAP, which clears the count.
         always_ff @(posedge clk) begin
            if (rst) begin
               countReg <= '0;
            end else if (clear) begin
               countReg <= '0;
            end else if (waiting && !mem_ready) begin
               countReg <= countReg + 1'b1;
            end
         end

         // A ready in the same cycle as the limit still completes the access.
         assign expired = waiting && !mem_ready && (countReg == CNT_W'(MEM_TIMEOUT));
      end else begin : gNoTimeout
         assign expired = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/multicycle_ctrl_v2.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_v2
// Control FSM for the multi-cycle MIPS datapath with memory-ready wait
// states, memory timeout trap, JR and illegal-opcode trap.
// Inputs : clk, rst (sync, active high), OP/funct from the instruction
//          register, mem_ready from the memory interface.
// Outputs: datapath mux selects and enables (RegDst, RegWrite, ALUSrcA/B,
//          ALUOp, ALUctrInst, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
//          PCWriteCond, PCWrite, PCCondSrc, PCSource), trap/trap_cause and
//          the current state for debug.
// Outputs are Moore from the state, except IRWrite/PCWrite in IF which only
// fire on the cycle memory delivers the instruction.
// ---------------------------------------------------------------------------
module multicycle_ctrl_v2
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT  = 15,
   parameter bit TRAP_ILLEGAL = 1'b1,
   parameter int STATE_W      = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         OP,
   input  logic [5:0]         funct,
   input  logic               mem_ready,
   output logic [1:0]         RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic               ALUctrInst,
   output logic               IorD,
   output logic               IRWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic [1:0]         MemtoReg,
   output logic               PCWriteCond,
   output logic               PCWrite,
   output logic               PCCondSrc,
   output logic [1:0]         PCSource,
   output logic               trap,
   output logic [1:0]         trap_cause,
   output logic [STATE_W-1:0] state
);

   ctrlState_t stateReg, stateNext;
   logic [1:0] trapCauseReg, trapCauseNext;
   logic       waiting, waitClear, expired;

   // Count restarts whenever a memory state is entered, even IF right after
   // MEM_ST, so each access gets its full timeout budget.
   assign waiting   = isMemState(stateReg);
   assign waitClear = !waiting || (stateNext != stateReg);

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) waitTimer (
      .clk      (clk),
      .rst      (rst),
      .clear    (waitClear),
      .waiting  (waiting),
      .mem_ready(mem_ready),
      .expired  (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg     <= S_IDLE;
         trapCauseReg <= CAUSE_NONE;
      end else begin
         stateReg     <= stateNext;
         trapCauseReg <= trapCauseNext;
      end
   end

   assign state      = STATE_W'(stateReg);
   assign trap_cause = trapCauseReg;

   always_comb begin
      stateNext     = stateReg;
      trapCauseNext = trapCauseReg;
      RegDst        = REGDST_RT;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = ALUB_B;
      ALUOp         = ALUOP_ADD;
      ALUctrInst    = 1'b0;
      IorD          = 1'b0;
      IRWrite       = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      MemtoReg      = MEMTOREG_ALU;
      PCWriteCond   = 1'b0;
      PCWrite       = 1'b0;
      PCCondSrc     = 1'b0;
      PCSource      = PCSRC_ALU;
      trap          = 1'b0;

      case (stateReg)
         S_IDLE: stateNext = S_IF;
         S_IF: begin
            MemRead = 1'b1;
            ALUSrcB = ALUB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) begin
               stateNext = S_ID;
            end else if (expired) begin
               stateNext     = S_TRAP;
               trapCauseNext = CAUSE_TIMEOUT;
            end
         end
         S_ID: begin
            ALUSrcB = ALUB_IMMSH;
            case (OP)
               OP_RTYPE:        stateNext = (funct == FUNCT_JR) ? S_JR : S_EX_R;
               OP_J:            stateNext = S_J;
               OP_JAL:          stateNext = S_JAL_LINK;
               OP_ADDI:         stateNext = S_EX_I;
               OP_ANDI, OP_ORI: stateNext = S_EX_LOGI;
               OP_LW, OP_SW:    stateNext = S_EX_LS;
               OP_BEQ:          stateNext = S_BEQ;
               OP_BNE:          stateNext = S_BNE;
               default: begin
                  if (TRAP_ILLEGAL) begin
                     stateNext     = S_TRAP;
                     trapCauseNext = CAUSE_ILLEGAL;
                  end else begin
                     stateNext = S_EX_R;
                  end
               end
            endcase
         end
         S_EX_LS: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = ALUB_IMM;
            stateNext = (OP == OP_LW) ? S_MEM_RD : S_MEM_ST;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) begin
               stateNext = S_WB_LS;
            end else if (expired) begin
               stateNext     = S_TRAP;
               trapCauseNext = CAUSE_TIMEOUT;
            end
         end
         S_WB_LS: begin
            RegWrite  = 1'b1;
            RegDst    = REGDST_RT;
            MemtoReg  = MEMTOREG_MDR;
            stateNext = S_IF;
         end
         S_MEM_ST: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               stateNext = S_IF;
            end else if (expired) begin
               stateNext     = S_TRAP;
               trapCauseNext = CAUSE_TIMEOUT;
            end
         end
         S_EX_R: begin
            ALUSrcA   = 1'b1;
            ALUOp     = ALUOP_FUNCT;
            stateNext = S_WB_R;
         end
         S_WB_R: begin
            RegWrite  = 1'b1;
            RegDst    = REGDST_RD;
            stateNext = S_IF;
         end
         S_BEQ, S_BNE: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            PCCondSrc   = (stateReg == S_BEQ);
            stateNext   = S_IF;
         end
         S_J: begin
            PCWrite   = 1'b1;
            PCSource  = PCSRC_JUMP;
            stateNext = S_IF;
         end
         S_EX_I: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = ALUB_IMM;
            stateNext = S_WB_I;
         end
         S_WB_I: begin
            RegWrite  = 1'b1;
            RegDst    = REGDST_RT;
            MemtoReg  = MEMTOREG_ALU;
            stateNext = S_IF;
         end
         S_JAL_LINK: begin
            // Link first, then reuse the plain jump state for the PC update.
            RegWrite  = 1'b1;
            RegDst    = REGDST_RA;
            MemtoReg  = MEMTOREG_PC;
            stateNext = S_J;
         end
         S_EX_LOGI: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = ALUB_IMM;
            ALUOp      = ALUOP_LOGI;
            ALUctrInst = 1'b1;
            stateNext  = S_WB_I;
         end
         S_JR: begin
            PCWrite   = 1'b1;
            PCSource  = PCSRC_REG;
            stateNext = S_IF;
         end
         S_TRAP: begin
            trap      = 1'b1;
            stateNext = S_TRAP;
         end
         default: stateNext = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_v2
// Self-checking bench: each instruction is expanded into the list of states
// it should visit (with planned memory wait cycles), then stepped cycle by
// cycle comparing state, all control outputs and trap cause.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_v2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] OP = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       mem_ready = 1'b0;
   logic [1:0] RegDst, ALUSrcB, ALUOp, MemtoReg, PCSource, trap_cause;
   logic       RegWrite, ALUSrcA, ALUctrInst, IorD, IRWrite, MemRead, MemWrite;
   logic       PCWriteCond, PCWrite, PCCondSrc, trap;
   logic [4:0] state;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_v2 dut (
      .clk(clk), .rst(rst), .OP(OP), .funct(funct), .mem_ready(mem_ready),
      .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .ALUctrInst(ALUctrInst), .IorD(IorD), .IRWrite(IRWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .PCCondSrc(PCCondSrc),
      .PCSource(PCSource), .trap(trap), .trap_cause(trap_cause), .state(state)
   );

   typedef struct packed {
      logic [1:0] RegDst;
      logic       RegWrite;
      logic       ALUSrcA;
      logic [1:0] ALUSrcB;
      logic [1:0] ALUOp;
      logic       ALUctrInst;
      logic       IorD;
      logic       IRWrite;
      logic       MemRead;
      logic       MemWrite;
      logic [1:0] MemtoReg;
      logic       PCWriteCond;
      logic       PCWrite;
      logic       PCCondSrc;
      logic [1:0] PCSource;
      logic       trap;
   } ctrl_t;

   ctrl_t obsCtrl;
   assign obsCtrl = {RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, ALUctrInst, IorD,
                     IRWrite, MemRead, MemWrite, MemtoReg, PCWriteCond, PCWrite,
                     PCCondSrc, PCSource, trap};

   // Control table straight from the state descriptions.
   function automatic ctrl_t expCtrl(int s, logic mr);
      ctrl_t c = '0;
      case (s)
         0:  begin c.MemRead = 1; c.ALUSrcB = 2'b01; c.IRWrite = mr; c.PCWrite = mr; end
         1:  c.ALUSrcB = 2'b11;
         2:  begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
         3:  begin c.MemRead = 1; c.IorD = 1; end
         4:  begin c.RegWrite = 1; c.MemtoReg = 2'b01; end
         5:  begin c.MemWrite = 1; c.IorD = 1; end
         6:  begin c.ALUSrcA = 1; c.ALUOp = 2'b10; end
         7:  begin c.RegWrite = 1; c.RegDst = 2'b01; end
         8, 10: begin
            c.ALUSrcA = 1; c.ALUOp = 2'b01; c.PCWriteCond = 1; c.PCSource = 2'b01;
            c.PCCondSrc = (s == 8);
         end
         9:  begin c.PCWrite = 1; c.PCSource = 2'b10; end
         11: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
         12: c.RegWrite = 1;
         13: begin c.RegWrite = 1; c.RegDst = 2'b10; c.MemtoReg = 2'b10; end
         14: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.ALUOp = 2'b11; c.ALUctrInst = 1; end
         15: begin c.PCWrite = 1; c.PCSource = 2'b11; end
         16: c.trap = 1;
         default: ;
      endcase
      return c;
   endfunction

   // Expected per-cycle plan: state, mem_ready to drive, trap cause
   int         planS[$];
   logic       planMr[$];
   logic [1:0] planC[$];

   task automatic push(int s, logic mr, logic [1:0] c);
      planS.push_back(s);
      planMr.push_back(mr);
      planC.push_back(c);
   endtask

   task automatic pushPlain(int s);
      push(s, 1'($urandom_range(0, 1)), 2'b00);
   endtask

   // Memory state: w stalled cycles, then the completing cycle.
   task automatic pushWait(int s, int w);
      for (int i = 0; i < w; i++) push(s, 1'b0, 2'b00);
      push(s, 1'b1, 2'b00);
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(int s, logic mr, logic [1:0] c);
      @(negedge clk);
      mem_ready = mr;
      #1;
      check("state", 32'(state), 32'(s));
      check("ctrl", 32'(obsCtrl), 32'(expCtrl(s, mr)));
      check("trap_cause", 32'(trap_cause), 32'(c));
   endtask

   task automatic runPlan(string name);
      int n;
      n = planS.size();
      while (planS.size() > 0) begin
         step(planS.pop_front(), planMr.pop_front(), planC.pop_front());
      end
      $display("instr %s op=%b funct=%b cycles=%0d", name, OP, funct, n);
   endtask

   // Path of one instruction through the FSM by its opcode class.
   task automatic runInstr(string name, logic [5:0] op, logic [5:0] fn, int wIf, int wMem);
      OP = op;
      funct = fn;
      pushWait(0, wIf);
      pushPlain(1);
      case (op)
         6'b000000: if (fn == 6'b001000) pushPlain(15);
                    else begin pushPlain(6); pushPlain(7); end
         6'b100011: begin pushPlain(2); pushWait(3, wMem); pushPlain(4); end
         6'b101011: begin pushPlain(2); pushWait(5, wMem); end
         6'b000100: pushPlain(8);
         6'b000101: pushPlain(10);
         6'b000010: pushPlain(9);
         6'b000011: begin pushPlain(13); pushPlain(9); end
         6'b001000: begin pushPlain(11); pushPlain(12); end
         6'b001100, 6'b001101: begin pushPlain(14); pushPlain(12); end
         default: for (int i = 0; i < 20; i++) push(16, 1'($urandom_range(0, 1)), 2'b01);
      endcase
      runPlan(name);
   endtask

   task automatic doReset(int cycles);
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b0;
      repeat (cycles) @(negedge clk);
      #1;
      check("rst_state", 32'(state), 32'h1F);
      check("rst_ctrl", 32'(obsCtrl), 32'd0);
      check("rst_cause", 32'(trap_cause), 32'd0);
      rst = 1'b0;
      $display("reset for %0d cycles", cycles);
   endtask

   logic [5:0] opTable [11];
   logic [5:0] rOp, rFn;

   initial begin
      opTable = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
                  6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D};

      doReset(2);

      // Directed: R-type, LW with waits, JAL, JR, SW completing at the limit
      runInstr("add", 6'b000000, 6'b100000, 0, 0);
      runInstr("lw_wait", 6'b100011, 6'b000000, 3, 2);
      runInstr("jal", 6'b000011, 6'b000000, 0, 0);
      runInstr("jr", 6'b000000, 6'b001000, 0, 0);
      runInstr("sw_ready_at_limit", 6'b101011, 6'b000000, 0, 15);

      // Random instruction mix with short waits
      for (int k = 0; k < 40; k++) begin
         int idx;
         idx = $urandom_range(0, 10);
         rOp = opTable[idx];
         rFn = 6'($urandom);
         if (idx == 0 && rFn == 6'b001000) rFn = 6'b100000;
         if (idx == 1) rFn = 6'b001000;
         runInstr("rand", rOp, rFn, $urandom_range(0, 5), $urandom_range(0, 5));
      end

      // Illegal opcode traps and holds until reset
      runInstr("illegal", 6'b111111, 6'b000000, 1, 0);
      doReset(1);

      // SW with memory stuck: 16 stalled cycles in MEM_ST, then timeout trap
      OP = 6'b101011;
      pushWait(0, 0);
      pushPlain(1);
      pushPlain(2);
      for (int i = 0; i < 16; i++) push(5, 1'b0, 2'b00);
      for (int i = 0; i < 3; i++) push(16, 1'($urandom_range(0, 1)), 2'b10);
      runPlan("sw_timeout");
      doReset(1);

      // Reset in the middle of a stalled load
      OP = 6'b100011;
      pushWait(0, 0);
      pushPlain(1);
      pushPlain(2);
      push(3, 1'b0, 2'b00);
      push(3, 1'b0, 2'b00);
      runPlan("lw_abort");
      doReset(1);

      runInstr("add_after", 6'b000000, 6'b100010, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
